// File: rtl/mseq_sync_ctrl.sv
// Sync controller for the 31-chip M-sequence correlator: peak search, period verification, lock, symbol decision.
// Define MSEQ_SYNC_STATS_EN to build the saturating miss_total counter; otherwise miss_total is tied to 0.
module mseq_sync_ctrl #(
   parameter int PERIOD   = 31,
   parameter int CORR_W   = 8,
   parameter int THRESH   = 56,
   parameter int LOCK_CNT = 3,
   parameter int MISS_CNT = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ce,
   input  logic [CORR_W-1:0]          corr,
   output logic                       lock,
   output logic [1:0]                 state,
   output logic [$clog2(PERIOD)-1:0]  phase,
   output logic                       sym_valid,
   output logic                       sym_bit,
   output logic [15:0]                miss_total
);

   localparam int PW = $clog2(PERIOD);
   localparam int HW = $clog2(LOCK_CNT + 1);
   localparam int MW = $clog2(MISS_CNT + 1);

   // Thresholds compared one bit wider than corr so neither side is truncated.
   localparam logic [CORR_W:0] POS_TH    = (CORR_W + 1)'(THRESH);
   localparam logic [CORR_W:0] NEG_TH    = (CORR_W + 1)'(2 * PERIOD - THRESH);
   localparam logic [PW-1:0]   PH_LAST   = PW'(PERIOD - 1);
   localparam logic [HW-1:0]   HITS_TERM = HW'(LOCK_CNT);
   localparam logic [HW-1:0]   HITS_LAST = HW'(LOCK_CNT - 1);
   localparam logic [MW-1:0]   MISS_LAST = MW'(MISS_CNT - 1);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } st_t;

   st_t           st;
   logic [HW-1:0] hits;
   logic [MW-1:0] misses;
   logic          pos;
   logic          neg;
   logic          peak;
   logic          at_exp;

   always_comb begin
      pos    = ({1'b0, corr} >= POS_TH);
      neg    = ({1'b0, corr} <= NEG_TH);
      peak   = pos | neg;
      at_exp = (phase == PH_LAST);
   end

   assign state = st;

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= SEARCH;
         lock      <= 1'b0;
         phase     <= '0;
         hits      <= '0;
         misses    <= '0;
         sym_valid <= 1'b0;
         sym_bit   <= 1'b0;
      end else begin
         sym_valid <= 1'b0;
         if (ce) begin
            case (st)
               SEARCH: begin
                  phase <= '0;
                  if (peak) begin
                     st   <= VERIFY;
                     hits <= HW'(1);
                  end
               end
               // Off-instant peaks are ignored so a spurious peak cannot re-anchor the phase.
               VERIFY: begin
                  if (at_exp) begin
                     phase <= '0;
                     if (!peak) begin
                        st   <= SEARCH;
                        hits <= '0;
                     end else if (hits >= HITS_LAST) begin
                        st        <= LOCKED;
                        lock      <= 1'b1;
                        hits      <= HITS_TERM;
                        misses    <= '0;
                        sym_valid <= 1'b1;
                        sym_bit   <= pos;
                     end else begin
                        hits <= hits + HW'(1);
                     end
                  end else begin
                     phase <= phase + PW'(1);
                  end
               end
               LOCKED: begin
                  if (at_exp) begin
                     phase <= '0;
                     if (peak) begin
                        misses    <= '0;
                        sym_valid <= 1'b1;
                        sym_bit   <= pos;
                     end else if (misses >= MISS_LAST) begin
                        st     <= SEARCH;
                        lock   <= 1'b0;
                        hits   <= '0;
                        misses <= '0;
                     end else begin
                        misses <= misses + MW'(1);
                     end
                  end else begin
                     phase <= phase + PW'(1);
                  end
               end
               default: begin
                  st     <= SEARCH;
                  lock   <= 1'b0;
                  phase  <= '0;
                  hits   <= '0;
                  misses <= '0;
               end
            endcase
         end
      end
   end

`ifdef MSEQ_SYNC_STATS_EN
   logic lock_miss;
   assign lock_miss = ce & (st == LOCKED) & at_exp & ~peak;

   // Survives loss of lock; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst)
         miss_total <= '0;
      else if (lock_miss && (miss_total != 16'hFFFF))
         miss_total <= miss_total + 16'd1;
   end
`else
   assign miss_total = '0;
`endif

endmodule

// File: doc/mseq_sync_ctrl.md
# mseq_sync_ctrl

Synchronisation controller for the 31-chip M-sequence correlator (`dec`). It watches the correlator's per-chip correlation value and searches for a correlation peak. It then verifies that peaks recur with the sequence period, declares lock, and emits one decided data bit per period from the peak polarity. In the receive path it sits directly after `dec`; downstream symbol logic consumes only `sym_valid`/`sym_bit`/`lock`.

## Interface
- `PERIOD`, 31, sequence length in chips; expected peak spacing in cycles.
- `CORR_W`, 8, width of correlation input.
- `THRESH`, 56, positive-peak threshold; full match = 2·PERIOD = 62; must satisfy PERIOD < THRESH ≤ 2·PERIOD.
- `LOCK_CNT`, 3, consecutive on-time peaks (including the first) required for lock; ≥2.
- `MISS_CNT`, 2, consecutive missed peaks in LOCK that drop lock; ≥1.

- `clk`  in  1  chip clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ce`  in  1  chip enable; low = hold all state, sample nothing.
- `corr`  in  CORR_W  unsigned correlation from `dec` (`data`), valid every `ce` cycle.
- `lock`  out  1  registered; high in LOCK.
- `state`  out  2  registered; 0 SEARCH, 1 VERIFY, 2 LOCK.
- `phase`  out  $clog2(PERIOD)  chips since last expected/acquired peak.
- `sym_valid`  out  1  one-cycle pulse: decided symbol present.
- `sym_bit`  out  1  polarity of decided symbol; 1 = positive peak.
- `miss_total`  out  16  cumulative misses (see Configuration).

## Operation
- Peak classification, on each `ce` cycle: `pos` = corr ≥ THRESH; `neg` = corr ≤ 2·PERIOD−THRESH; `peak` = pos|neg. The two are disjoint by the parameter rule. Comparison is unsigned at CORR_W+1 bits, with no truncation.
- `phase` counts 0..PERIOD−1 and wraps. The expected instant is phase == PERIOD−1 (exactly PERIOD `ce` cycles after the previous reference peak).
- SEARCH: `phase` = 0 and counters = 0. A `peak` causes phase←0, hits←1, state←VERIFY. Either polarity is accepted.
- VERIFY: `phase` increments. Peaks off the expected instant are ignored and do not re-anchor.
  - At the expected instant with `peak`: hits++ and phase←0. If hits reaches LOCK_CNT: state←LOCK, emit symbol.
  - At the expected instant without `peak`: state←SEARCH, hits←0.
- LOCK: `phase` increments and wraps at the expected instant regardless of hit or miss.
  - At the expected instant with `peak`: emit symbol, misses←0.
  - Without `peak`: misses++, no symbol. If misses reaches MISS_CNT: state←SEARCH, all counters 0.
- Symbol emission: sym_valid=1 and sym_bit=`pos` for one cycle.
- Counters saturate at their terminal values; they never wrap.

## Timing
- All outputs are registered. The response to a `corr` sample at edge N appears after edge N. Latency is 1 cycle for `sym_valid`, `lock`, `state`, `phase`.
- Reset values: lock=0, state=0 (SEARCH), phase=0, sym_valid=0, sym_bit=0, miss_total=0. Internal hits and misses are also 0.
- `rst` mid-operation: the next cycle is SEARCH with all outputs at reset values. A peak on the same cycle as `rst` is discarded.
- `ce`=0: all registers hold, `sym_valid` forced 0, and the `corr` value is ignored. `ce` gaps stretch the expected instant by the gap length.
- `sym_valid` is never high on two consecutive cycles. The minimum spacing is PERIOD `ce` cycles.
- `lock` rises on the same cycle as the first `sym_valid`. It falls on the cycle after the MISS_CNT-th consecutive miss.

## Configuration
- `MSEQ_SYNC_STATS_EN` defined:
  - `miss_total` increments on every LOCK miss and saturates at 65535.
  - Only `rst` clears it; loss of lock does not.
- Not defined: `miss_total` is tied to 0 and no counter logic is synthesised. The port list is unchanged.

## Test plan
Default parameters throughout; "cycle" means the `corr` sample edge.
- Reset hold: `rst` high for 3 cycles, corr=62 → all outputs 0, state=0 throughout and on the first cycle after release.
- Acquisition: corr=62 at cycles 10 and 41, corr=0 at cycle 72, corr=31 elsewhere → VERIFY after 10; lock=1, state=2, sym_valid with sym_bit=0 after 72. A further corr=62 at 103 → sym_bit=1.
- False spacing: corr=62 at 10 and 40 only → peak at 40 ignored; state=0 after cycle 41.
- Thresholds: with lock held, set corr at expected instants to 56, 6, 55, 7.
  - 56 → sym_bit=1.
  - 6 → sym_bit=0.
  - 55 → miss.
  - 7 → second consecutive miss, so lock drops and state=0.
- Lock loss and stats: in LOCK, miss one expected peak → lock stays 1, no sym_valid, miss_total=1 (macro on). Miss the next one too → lock=0, state=0, miss_total=2. Macro off → miss_total=0.
- Chip enable: in LOCK, `ce`=0 for 5 cycles mid-period with corr=62 during the gap → no sym_valid during the gap. Next sym_valid appears 5 cycles later than without the gap, and lock is maintained.
